// File: rtl/seg_display_ctrl_pkg.sv
// Shared op-codes, mode encoding and spin frame patterns for the
// seven-segment display sequencer.
package seg_ctrl_pkg;

  localparam logic [1:0] OP_SHOW = 2'd0;
  localparam logic [1:0] OP_RAW  = 2'd1;
  localparam logic [1:0] OP_SPIN = 2'd2;
  localparam logic [1:0] OP_CTRL = 2'd3;

  typedef enum logic [1:0] {
    MODE_SHOW = 2'd0,
    MODE_RAW  = 2'd1,
    MODE_SPIN = 2'd2
  } mode_t;

  localparam logic [7:0] SPIN_F0 = 8'h01;
  localparam logic [7:0] SPIN_F1 = 8'h02;
  localparam logic [7:0] SPIN_F2 = 8'h04;
  localparam logic [7:0] SPIN_F3 = 8'h08;
  localparam logic [7:0] SPIN_F4 = 8'h10;
  localparam logic [7:0] SPIN_F5 = 8'h20;
  localparam logic [2:0] SPIN_LAST_FRAME = 3'd5;

  function automatic logic [7:0] frame_pat(input logic [2:0] f);
    case (f)
      3'd0:    frame_pat = SPIN_F0;
      3'd1:    frame_pat = SPIN_F1;
      3'd2:    frame_pat = SPIN_F2;
      3'd3:    frame_pat = SPIN_F3;
      3'd4:    frame_pat = SPIN_F4;
      3'd5:    frame_pat = SPIN_F5;
      default: frame_pat = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/seg_display_ctrl_if.sv
// Command channel from the processor write path to the display sequencer.
// A command transfers on every clock edge where cmd_valid_in and
// cmd_ready_out are both high; the master holds op/data stable while valid
// is high and not yet accepted, and ready never depends on valid.
interface seg_cmd_if;
  logic       cmd_valid_in;
  logic       cmd_ready_out;
  logic [1:0] cmd_op_in;
  logic [7:0] cmd_data_in;

  modport master (
    output cmd_valid_in,
    output cmd_op_in,
    output cmd_data_in,
    input  cmd_ready_out
  );

  modport slave (
    input  cmd_valid_in,
    input  cmd_op_in,
    input  cmd_data_in,
    output cmd_ready_out
  );
endinterface

// File: rtl/seg_display_ctrl_tick_gen.sv
// Free-running animation prescaler; tick_out is high for the one cycle the
// count sits at TICK_DIV-1. clr_in restarts the count at zero.
module seg_tick_gen #(
  parameter int TICK_DIV = 50000,
  parameter int TICK_W   = 16
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic clr_in,
  output logic tick_out
);

  localparam logic [TICK_W-1:0] LAST = TICK_W'(TICK_DIV - 1);

  logic [TICK_W-1:0] cnt;

  assign tick_out = (cnt == LAST);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt <= '0;
    end else if (clr_in || tick_out) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + TICK_W'(1);
    end
  end

endmodule

// File: rtl/seg_display_ctrl.sv
// Display command sequencer: holds the decoder inputs in registers and runs
// the spin animation and blink effect off a shared prescaler tick.
module seg_display_ctrl
  import seg_ctrl_pkg::*;
#(
  parameter int TICK_DIV = 50000,
  parameter int TICK_W   = 16
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  seg_cmd_if.slave   cmd,
  output logic [4:0] value_out,
  output logic [7:0] bit_array_out,
  output logic       anim_en_out,
  output logic       display_on_out,
  output logic       busy_out,
  output mode_t      dbg_mode
);

  logic       accept;
  logic       tick;
  logic       spin_clr;
  logic       ctrl_cmd;
  logic       ready_q;
  mode_t      mode;
  logic [2:0] frame;
  logic [3:0] rev;

  assign accept            = cmd.cmd_valid_in & ready_q;
  assign spin_clr          = accept && (cmd.cmd_op_in == OP_SPIN);
  assign ctrl_cmd          = accept && (cmd.cmd_op_in == OP_CTRL);
  assign cmd.cmd_ready_out = ready_q;
  assign dbg_mode          = mode;

  seg_tick_gen #(
    .TICK_DIV (TICK_DIV),
    .TICK_W   (TICK_W)
  ) u_tick_gen (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .clr_in   (spin_clr),
    .tick_out (tick)
  );

  // Mode sequencer. An accepted command takes priority over a frame advance
  // on the same tick; rev==0 marks an infinite spin that never exits.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      mode          <= MODE_SHOW;
      frame         <= 3'd0;
      rev           <= 4'd0;
      ready_q       <= 1'b1;
      busy_out      <= 1'b0;
      value_out     <= 5'd0;
      bit_array_out <= 8'd0;
      anim_en_out   <= 1'b0;
    end else if (accept) begin
      case (cmd.cmd_op_in)
        OP_SHOW: begin
          value_out   <= cmd.cmd_data_in[4:0];
          mode        <= MODE_SHOW;
          anim_en_out <= 1'b0;
        end
        OP_RAW: begin
          bit_array_out <= cmd.cmd_data_in;
          mode          <= MODE_RAW;
          anim_en_out   <= 1'b1;
        end
        OP_SPIN: begin
          rev           <= cmd.cmd_data_in[3:0];
          frame         <= 3'd0;
          bit_array_out <= frame_pat(3'd0);
          mode          <= MODE_SPIN;
          anim_en_out   <= 1'b1;
          if (cmd.cmd_data_in[3:0] != 4'd0) begin
            busy_out <= 1'b1;
            ready_q  <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end else if (tick && (mode == MODE_SPIN)) begin
      if (frame == SPIN_LAST_FRAME) begin
        frame         <= 3'd0;
        bit_array_out <= frame_pat(3'd0);
        if (rev == 4'd1) begin
          mode        <= MODE_SHOW;
          anim_en_out <= 1'b0;
          busy_out    <= 1'b0;
          ready_q     <= 1'b1;
        end else if (rev != 4'd0) begin
          rev <= rev - 4'd1;
        end
      end else begin
        frame         <= frame + 3'd1;
        bit_array_out <= frame_pat(frame + 3'd1);
      end
    end
  end

  logic       disp_en, blink_en, phase;
  logic [3:0] half_m1, bcnt;
  logic       nxt_disp_en, nxt_blink_en, nxt_phase;
  logic [3:0] nxt_half_m1, nxt_bcnt;

  // Blink timing. Turning blink on restarts the half-period count with the
  // display lit; a CTRL that keeps blink on leaves the running count alone.
  always_comb begin
    nxt_disp_en  = disp_en;
    nxt_blink_en = blink_en;
    nxt_phase    = phase;
    nxt_half_m1  = half_m1;
    nxt_bcnt     = bcnt;
    if (blink_en && tick) begin
      if (bcnt >= half_m1) begin
        nxt_bcnt  = 4'd0;
        nxt_phase = ~phase;
      end else begin
        nxt_bcnt = bcnt + 4'd1;
      end
    end
    if (ctrl_cmd) begin
      nxt_disp_en  = cmd.cmd_data_in[0];
      nxt_blink_en = cmd.cmd_data_in[1];
      nxt_half_m1  = cmd.cmd_data_in[7:4];
      if (!cmd.cmd_data_in[1]) begin
        nxt_phase = 1'b1;
      end else if (!blink_en) begin
        nxt_phase = 1'b1;
        nxt_bcnt  = 4'd0;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      disp_en        <= 1'b1;
      blink_en       <= 1'b0;
      phase          <= 1'b1;
      half_m1        <= 4'd0;
      bcnt           <= 4'd0;
      display_on_out <= 1'b1;
    end else begin
      disp_en        <= nxt_disp_en;
      blink_en       <= nxt_blink_en;
      phase          <= nxt_phase;
      half_m1        <= nxt_half_m1;
      bcnt           <= nxt_bcnt;
      display_on_out <= nxt_disp_en & (~nxt_blink_en | nxt_phase);
    end
  end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Bench for seg_display_ctrl: command vector table plus spin, blink and
// mid-spin reset sequences, all checked through an expected-output queue.
module tb_seg_display_ctrl;
  import seg_ctrl_pkg::*;

  localparam int TICK_DIV = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg_cmd_if cmd_bus ();

  logic [4:0] value;
  logic [7:0] bit_array;
  logic       anim_en, display_on, busy;
  mode_t      dbg_mode;

  seg_display_ctrl #(.TICK_DIV(TICK_DIV), .TICK_W(16)) dut (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
    .cmd            (cmd_bus),
    .value_out      (value),
    .bit_array_out  (bit_array),
    .anim_en_out    (anim_en),
    .display_on_out (display_on),
    .busy_out       (busy),
    .dbg_mode       (dbg_mode)
  );

  // ---------------- scoreboard ----------------
  // packing: {value[4:0], bits[7:0], anim, disp, ready, busy}
  localparam logic [16:0] M_ALL     = 17'h1FFFF;
  localparam logic [16:0] M_NO_BITS = 17'h1F00F;

  logic [16:0] exp_q[$];
  logic [16:0] msk_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [16:0] pack(input logic [4:0] v, input logic [7:0] b,
                                       input logic a, input logic d,
                                       input logic r, input logic bz);
    return {v, b, a, d, r, bz};
  endfunction

  function automatic logic [7:0] spin_bits(input int i);
    logic [7:0] one;
    one = 8'h01;
    return one << ((i / TICK_DIV) % 6);
  endfunction

  task automatic push_exp(input logic [16:0] e, input logic [16:0] m);
    exp_q.push_back(e);
    msk_q.push_back(m);
  endtask

  task automatic check_out(input string name);
    logic [16:0] e, m, act;
    act = pack(value, bit_array, anim_en, display_on, cmd_bus.cmd_ready_out, busy);
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: got %h but expected queue is empty", name, act);
    end else begin
      e = exp_q.pop_front();
      m = msk_q.pop_front();
      if ((act & m) != (e & m)) begin
        n_bad++;
        $display("FAIL %s: got v=%h b=%h a=%b d=%b r=%b busy=%b, expected v=%h b=%h a=%b d=%b r=%b busy=%b (mask %h)",
                 name, act[16:12], act[11:4], act[3], act[2], act[1], act[0],
                 e[16:12], e[11:4], e[3], e[2], e[1], e[0], m);
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic send_cmd(input logic [1:0] op, input logic [7:0] data);
    cmd_bus.cmd_valid_in = 1'b1;
    cmd_bus.cmd_op_in    = op;
    cmd_bus.cmd_data_in  = data;
    @(posedge clk);
    #1;
    cmd_bus.cmd_valid_in = 1'b0;
  endtask

  typedef struct {
    logic [1:0] op;
    logic [7:0] data;
    logic [4:0] v;
    logic [7:0] b;
    logic       a;
    logic       d;
  } vec_t;

  vec_t vecs[8];

  initial begin
    cmd_bus.cmd_valid_in = 1'b0;
    cmd_bus.cmd_op_in    = 2'd0;
    cmd_bus.cmd_data_in  = 8'd0;

    vecs[0] = '{OP_SHOW, 8'h13, 5'h13, 8'h00, 1'b0, 1'b1};
    vecs[1] = '{OP_RAW,  8'hA5, 5'h13, 8'hA5, 1'b1, 1'b1};
    vecs[2] = '{OP_SHOW, 8'h07, 5'h07, 8'hA5, 1'b0, 1'b1};
    vecs[3] = '{OP_SHOW, 8'hFF, 5'h1F, 8'hA5, 1'b0, 1'b1};
    vecs[4] = '{OP_RAW,  8'h00, 5'h1F, 8'h00, 1'b1, 1'b1};
    vecs[5] = '{OP_CTRL, 8'h00, 5'h1F, 8'h00, 1'b1, 1'b0};
    vecs[6] = '{OP_CTRL, 8'h01, 5'h1F, 8'h00, 1'b1, 1'b1};
    vecs[7] = '{OP_SHOW, 8'h09, 5'h09, 8'h00, 1'b0, 1'b1};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    push_exp(pack(5'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0), M_ALL);
    @(negedge clk);
    check_out("reset");

    // single-command table
    for (int i = 0; i < 8; i++) begin
      push_exp(pack(vecs[i].v, vecs[i].b, vecs[i].a, vecs[i].d, 1'b1, 1'b0), M_ALL);
      send_cmd(vecs[i].op, vecs[i].data);
      @(negedge clk);
      check_out($sformatf("vec%0d", i));
    end

    // finite spin, two revolutions, with a SHOW held pending the whole time
    for (int i = 0; i < 12 * TICK_DIV; i++)
      push_exp(pack(5'h09, spin_bits(i), 1'b1, 1'b1, 1'b0, 1'b1), M_ALL);
    send_cmd(OP_SPIN, 8'h02);
    cmd_bus.cmd_valid_in = 1'b1;
    cmd_bus.cmd_op_in    = OP_SHOW;
    cmd_bus.cmd_data_in  = 8'h1F;
    for (int i = 0; i < 12 * TICK_DIV; i++) begin
      @(negedge clk);
      check_out($sformatf("fspin%0d", i));
    end
    cmd_bus.cmd_valid_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      push_exp(pack(5'h09, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0), M_NO_BITS);
      @(negedge clk);
      check_out($sformatf("fspin_done%0d", i));
    end

    // infinite spin, past 12 ticks, then preempted by RAW at frame 3
    for (int i = 0; i <= 15 * TICK_DIV; i++)
      push_exp(pack(5'h09, spin_bits(i), 1'b1, 1'b1, 1'b1, 1'b0), M_ALL);
    send_cmd(OP_SPIN, 8'h00);
    for (int i = 0; i <= 15 * TICK_DIV; i++) begin
      @(negedge clk);
      check_out($sformatf("ispin%0d", i));
    end
    for (int i = 0; i < 8; i++)
      push_exp(pack(5'h09, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0), M_ALL);
    send_cmd(OP_RAW, 8'hFF);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_out($sformatf("ispin_raw%0d", i));
    end

    // blink: prescaler aligned by SPIN, so the first lit stretch is 6 cycles
    for (int i = 0; i < 6 + 3 * 8; i++)
      push_exp(pack(5'h05, 8'h00, 1'b0, (i < 6) || (i >= 14 && i < 22), 1'b1, 1'b0),
               M_NO_BITS);
    send_cmd(OP_SPIN, 8'h00);
    send_cmd(OP_SHOW, 8'h05);
    send_cmd(OP_CTRL, 8'h13);
    for (int i = 0; i < 6 + 3 * 8; i++) begin
      @(negedge clk);
      check_out($sformatf("blink%0d", i));
    end
    for (int i = 0; i < 10; i++)
      push_exp(pack(5'h05, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0), M_NO_BITS);
    send_cmd(OP_CTRL, 8'h00);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_out($sformatf("disp_off%0d", i));
    end
    for (int i = 0; i < 10; i++)
      push_exp(pack(5'h05, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0), M_NO_BITS);
    send_cmd(OP_CTRL, 8'h01);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_out($sformatf("disp_on%0d", i));
    end

    // asynchronous reset in frame 2 of a finite spin
    for (int i = 0; i < 10; i++)
      push_exp(pack(5'h05, spin_bits(i), 1'b1, 1'b1, 1'b0, 1'b1), M_ALL);
    send_cmd(OP_SPIN, 8'h05);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_out($sformatf("rspin%0d", i));
    end
    #2 rst_n = 1'b0;
    #1;
    push_exp(pack(5'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0), M_ALL);
    check_out("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      push_exp(pack(5'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0), M_ALL);
      @(negedge clk);
      check_out($sformatf("post_reset%0d", i));
    end
    push_exp(pack(5'h0C, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0), M_ALL);
    send_cmd(OP_SHOW, 8'h0C);
    @(negedge clk);
    check_out("post_reset_show");

    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL leftover: %0d expected entries never compared, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at 200000, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seg_display_ctrl.md
Name: seg_display_ctrl

Overview:
Sequencer for the seven-segment decoder. It accepts display commands from the processor over a valid/ready interface and drives the decoder's value, raw bit-array, animation-enable and display-on inputs from registers. It also generates a segment-chase "spin" animation and a blink effect, both timed by an internal prescaler. It sits between the processor's I/O write path and the decoder.

Parameters:
TICK_DIV, 50000, clock cycles per animation tick (≥2); the bench uses 4.
TICK_W, 16, prescaler counter width; must hold TICK_DIV-1.

Ports:
clk_in  input  1  clock
rst_n_in  input  1  asynchronous active-low reset
cmd_valid_in  input  1  command valid
cmd_ready_out  output  1  command ready; a command is accepted on a cycle with valid&ready
cmd_op_in  input  2  0=SHOW, 1=RAW, 2=SPIN, 3=CTRL
cmd_data_in  input  8  command operand
value_out  output  5  to decoder value input; bit4 is the decimal point
bit_array_out  output  8  to decoder raw segment pattern
anim_en_out  output  1  to decoder; 1 selects bit_array_out
display_on_out  output  1  to decoder display enable
busy_out  output  1  1 while a finite SPIN is running

Behaviour:
- Clock and reset: one clock, clk_in; reset rst_n_in is asynchronous, active-low.
- Reset values:
  - value_out=0, bit_array_out=0, anim_en_out=0, display_on_out=1, busy_out=0, cmd_ready_out=1.
  - Mode=SHOW, disp_en=1, blink off, prescaler=0.
  - Reset asserted mid-SPIN aborts it immediately to these values.
- All outputs are registered. A command accepted in cycle N takes effect on the outputs in cycle N+1.
- Modes:
  - SHOW: anim_en_out=0, value_out = held value.
  - RAW: anim_en_out=1, bit_array_out = held pattern.
  - SPIN: anim_en_out=1, bit_array_out = one-hot frame.
- Commands:
  - SHOW: value_out←data[4:0]; mode→SHOW (aborts an infinite SPIN).
  - RAW: bit_array_out←data; mode→RAW.
  - SPIN: count←data[3:0]; frame←0; prescaler←0; mode→SPIN.
    - count=0 means infinite: ready stays 1, busy=0, and any later command preempts it.
    - count>0 means finite: busy_out=1 and cmd_ready_out=0 from N+1 until completion; no command is accepted meanwhile.
  - CTRL: disp_en←data[0]; blink_en←data[1]; blink_half←data[7:4]+1 ticks (range 1..16). Mode is unchanged, so CTRL issued during an infinite SPIN leaves the spin running.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick is a one-cycle pulse on the cycle the count equals TICK_DIV-1.
  - Runs in all modes.
- SPIN frames:
  - frame 0..5 maps to bit_array_out = 8'h01, 02, 04, 08, 10, 20 (segments 1..6); bit7=0.
  - On tick: frame increments; 5 wraps to 0 and ends one revolution.
  - Each frame lasts exactly TICK_DIV cycles, the first included, because entry clears the prescaler.
  - Finite spin: at the tick that ends the last revolution, mode→SHOW with the pre-spin value_out retained, busy_out→0, and cmd_ready_out→1 in the following cycle.
- Blink:
  - Off: display_on_out = disp_en.
  - Off→on via CTRL: phase←1 and the tick counter←0.
  - On: display_on_out = disp_en & phase; phase toggles each blink_half ticks.
  - CTRL with data[1]=0 forces phase=1.
- Simultaneous events:
  - A command accepted on a tick cycle wins over that tick's frame advance.
  - The blink counter still consumes the tick, unless the command is CTRL enabling blink, which restarts it.
- Widths: the revolution counter is 4 bits and the blink counter 4 bits; decrements never underflow because exit happens at 1.

Decomposition:
- Package seg_ctrl_pkg holds:
  - the op-code localparams OP_SHOW/OP_RAW/OP_SPIN/OP_CTRL;
  - the mode encoding MODE_SHOW/MODE_RAW/MODE_SPIN;
  - the SPIN frame pattern constants.
- One sub-module, seg_tick_gen, contains the TICK_DIV prescaler: ports clk_in, rst_n_in, clr_in; output tick_out.
- The decoder is instantiated by the parent, not inside this block.

Test Plan:
- Reset: after release, value_out=0, anim_en_out=0, display_on_out=1, cmd_ready_out=1. SHOW data=8'h13 → next cycle value_out=5'h13, anim_en_out=0.
- RAW data=8'hA5 → next cycle anim_en_out=1, bit_array_out=8'hA5. A following SHOW 8'h07 → anim_en_out=0, value_out=7.
- Finite SPIN (TICK_DIV=4), count=2 after SHOW 8'h09:
  - bit_array_out steps 01,02,04,08,10,20 twice, 4 cycles per frame;
  - busy_out=1 and cmd_ready_out=0 for 48 cycles; a valid SHOW held during this time is not accepted;
  - then anim_en_out=0, value_out=9, ready=1.
- Infinite SPIN (count=0): frames keep cycling past 12 ticks with ready=1. RAW 8'hFF issued at frame 3 → next cycle bit_array_out=8'hFF, spin stopped.
- Blink: CTRL data=8'h13 (half=2 ticks, on, blink) → display_on_out follows the pattern 1 for 8 cycles, 0 for 8, repeating. CTRL 8'h00 → display_on_out=0 constantly. CTRL 8'h01 → 1 constantly.
- Async reset mid finite SPIN (frame 2): outputs return to reset values asynchronously. After release, ready=1 and busy=0.
